// File: rtl/fc_layer_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fc_layer_sequencer_pkg
// Shared definitions for the fully-connected layer sequencer: the sequencer
// state type, the MAC pipeline depth, the default layer geometry and small
// width helpers used to size addresses, products and the accumulator.
// ----------------------------------------------------------------------------
package fc_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        BIAS,
        OUT,
        DONE
    } fc_state_e;

    // Register stages between the first data beat and the accumulator input
    // (product register + data-valid tag). DRAIN lasts this many cycles.
    localparam int MAC_PIPE = 2;

    localparam int DEF_N_IN  = 3136;
    localparam int DEF_N_OUT = 10;
    localparam int DEF_IN_W  = 30;
    localparam int DEF_W_W   = 9;

    // Index width for a range of n values; never collapses to zero bits.
    function automatic int clogW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width large enough that a full dot product plus bias
    // can never overflow.
    function automatic int accWidth(input int nIn, input int inW, input int wW);
        return inW + wW + clogW(nIn);
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// fc_layer_sequencer_if
// Bundles the three synchronous-read buffer ports (input features, weights,
// biases) and the valid/ready result port of the FC sequencer.
//   master : sequencer side - drives addresses and the result port,
//            receives read data and out_ready.
//   slave  : environment side - memories and the downstream consumer.
// Read data is expected one clock after the address it belongs to.
// ----------------------------------------------------------------------------
interface fc_layer_sequencer_if
    import fc_layer_sequencer_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int IN_W  = DEF_IN_W,
    parameter int W_W   = DEF_W_W
);

    localparam int ADDR_IN_W = clogW(N_IN);
    localparam int ADDR_W_W  = clogW(N_IN * N_OUT);
    localparam int IDX_W     = clogW(N_OUT);
    localparam int ACC_W     = accWidth(N_IN, IN_W, W_W);

    logic        [ADDR_IN_W-1:0] in_addr;
    logic signed [IN_W-1:0]      in_data;
    logic        [ADDR_W_W-1:0]  w_addr;
    logic signed [W_W-1:0]       w_data;
    logic        [IDX_W-1:0]     b_addr;
    logic signed [W_W-1:0]       b_data;
    logic        [IDX_W-1:0]     out_idx;
    logic signed [ACC_W-1:0]     out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_addr, w_addr, b_addr, out_idx, out_data, out_valid,
        input  in_data, w_data, b_data, out_ready
    );

    modport slave (
        input  in_addr, w_addr, b_addr, out_idx, out_data, out_valid,
        output in_data, w_data, b_data, out_ready
    );

endinterface

// File: rtl/fc_layer_sequencer_mac_pipe.sv
// ----------------------------------------------------------------------------
// fc_layer_sequencer_mac_pipe
// Registered signed multiply-accumulate shared by every neuron of the layer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_issue    : an address pair was issued this cycle (data arrives next cycle)
//   i_clear    : zero the accumulator for a new neuron
//   i_biasEn   : add i_bias into the accumulator this cycle
//   i_inData   : signed input feature (read data)
//   i_wData    : signed weight (read data)
//   i_bias     : signed bias (read data)
//   o_acc      : signed accumulator
// Timing: issue at t -> operands at t+1 -> product register at t+2 ->
// accumulator updated at t+3.
// ----------------------------------------------------------------------------
module fc_layer_sequencer_mac_pipe
    import fc_layer_sequencer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = accWidth(DEF_N_IN, DEF_IN_W, DEF_W_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_issue,
    input  logic                    i_clear,
    input  logic                    i_biasEn,
    input  logic signed [IN_W-1:0]  i_inData,
    input  logic signed [W_W-1:0]   i_wData,
    input  logic signed [W_W-1:0]   i_bias,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int PROD_W = IN_W + W_W;

    logic                     r_tagData;
    logic                     r_tagProd;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [PROD_W-1:0] w_inExt;
    logic signed [PROD_W-1:0] w_wExt;

    // Operands are sign-extended to the full product width so the multiply
    // is exact.
    assign w_inExt = PROD_W'(i_inData);
    assign w_wExt  = PROD_W'(i_wData);

    // Valid tags follow each issued pair through the pipe, so only real
    // products are accumulated and DRAIN-cycle reads are ignored. Clear and
    // bias never coincide with a tagged product because of how the sequencer
    // orders its states, so the priority order below loses nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tagData <= 1'b0;
            r_tagProd <= 1'b0;
            r_prod    <= '0;
            r_acc     <= '0;
        end else begin
            r_tagData <= i_issue;
            r_tagProd <= r_tagData;
            r_prod    <= w_inExt * w_wExt;
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_biasEn) begin
                r_acc <= r_acc + ACC_W'(i_bias);
            end else if (r_tagProd) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fc_layer_sequencer.sv
// ----------------------------------------------------------------------------
// fc_layer_sequencer
// Runs one shared MAC over a whole fully-connected layer. For each output
// neuron j it streams N_IN input/weight pairs, adds bias j and presents the
// result on a valid/ready port before moving to neuron j+1.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : one-cycle run request, only honoured in IDLE
//   o_busy     : high while a layer is in progress (low in DONE)
//   o_done_fc  : one-cycle pulse after the last result is accepted
//   io_bus     : buffer read ports and result handshake (master modport)
// Build option:
//   FC_RELU_EN : when defined, negative results are presented as zero.
// ----------------------------------------------------------------------------
module fc_layer_sequencer
    import fc_layer_sequencer_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int IN_W  = DEF_IN_W,
    parameter int W_W   = DEF_W_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done_fc,
    fc_layer_sequencer_if.master        io_bus
);

    localparam int ADDR_IN_W = clogW(N_IN);
    localparam int ADDR_W_W  = clogW(N_IN * N_OUT);
    localparam int IDX_W     = clogW(N_OUT);
    localparam int ACC_W     = accWidth(N_IN, IN_W, W_W);
    localparam int DRAIN_W   = clogW(MAC_PIPE);

    localparam logic [ADDR_IN_W-1:0] LAST_I     = ADDR_IN_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]     LAST_J     = IDX_W'(N_OUT - 1);
    localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(MAC_PIPE - 1);

    fc_state_e              r_state;
    fc_state_e              w_nextState;
    logic [ADDR_IN_W-1:0]   r_i;
    logic [IDX_W-1:0]       r_j;
    logic [ADDR_W_W-1:0]    r_wAddr;
    logic [DRAIN_W-1:0]     r_drainCnt;

    logic                   w_lastI;
    logic                   w_lastJ;
    logic                   w_lastDrain;
    logic                   w_macIssue;
    logic                   w_macClear;
    logic                   w_biasEn;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_result;

    assign w_lastI     = (r_i == LAST_I);
    assign w_lastJ     = (r_j == LAST_J);
    assign w_lastDrain = (r_drainCnt == LAST_DRAIN);

    // Next state and per-cycle MAC controls. The accumulator is cleared in
    // the cycle that launches FETCH, so a new neuron never sees stale sums.
    always_comb begin
        w_nextState = r_state;
        w_macIssue  = 1'b0;
        w_macClear  = 1'b0;
        w_biasEn    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = FETCH;
                    w_macClear  = 1'b1;
                end
            end
            FETCH: begin
                w_macIssue = 1'b1;
                if (w_lastI) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastDrain) begin
                    w_nextState = BIAS;
                end
            end
            BIAS: begin
                w_biasEn    = 1'b1;
                w_nextState = OUT;
            end
            OUT: begin
                if (io_bus.out_ready) begin
                    if (w_lastJ) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = FETCH;
                        w_macClear  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register and counters. The weight address is kept as a running
    // counter (j*N_IN + i) instead of a multiply; it stops on the last weight
    // of a neuron and only steps on into the next neuron at the transfer, so
    // it never points past the end of the weight ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_wAddr    <= '0;
            r_drainCnt <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_wAddr <= '0;
                    end
                end
                FETCH: begin
                    r_drainCnt <= '0;
                    if (w_lastI) begin
                        r_i <= '0;
                    end else begin
                        r_i     <= r_i + ADDR_IN_W'(1);
                        r_wAddr <= r_wAddr + ADDR_W_W'(1);
                    end
                end
                DRAIN: begin
                    r_drainCnt <= w_lastDrain ? '0 : r_drainCnt + DRAIN_W'(1);
                end
                OUT: begin
                    if (io_bus.out_ready) begin
                        if (w_lastJ) begin
                            r_j     <= '0;
                            r_wAddr <= '0;
                        end else begin
                            r_j     <= r_j + IDX_W'(1);
                            r_wAddr <= r_wAddr + ADDR_W_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fc_layer_sequencer_mac_pipe #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_issue  (w_macIssue),
        .i_clear  (w_macClear),
        .i_biasEn (w_biasEn),
        .i_inData (io_bus.in_data),
        .i_wData  (io_bus.w_data),
        .i_bias   (io_bus.b_data),
        .o_acc    (w_acc)
    );

`ifdef FC_RELU_EN
    assign w_result = w_acc[ACC_W-1] ? '0 : w_acc;
`else
    assign w_result = w_acc;
`endif

    // Bias address is simply j, held for the whole neuron.
    assign io_bus.in_addr   = r_i;
    assign io_bus.w_addr    = r_wAddr;
    assign io_bus.b_addr    = r_j;
    assign io_bus.out_idx   = r_j;
    assign io_bus.out_valid = (r_state == OUT);
    assign io_bus.out_data  = (r_state == OUT) ? w_result : '0;

    assign o_busy    = (r_state == FETCH) || (r_state == DRAIN) ||
                       (r_state == BIAS)  || (r_state == OUT);
    assign o_done_fc = (r_state == DONE);

endmodule
